// File: rtl/div_sequencer.sv
// -----------------------------------------------------------------------------
// div_sequencer
//
// Multi-cycle iterative divider and controller for the RV32M DIV, DIVU, REM
// and REMU operations. The execute stage hands an operation over through a
// valid/ready request and stalls on `busy` until the result is returned
// through a valid/ready response. The core is a radix-2 restoring divider
// that runs one step per cycle, for 32 steps, on operand magnitudes. The
// sign is fixed up on the way into the result register.
//
// Ports:
//   clk         system clock, rising-edge active
//   rst_n       asynchronous active-low reset
//   req_valid   execute stage presents a divide operation
//   req_ready   request can be accepted (IDLE only)
//   opa         dividend
//   opb         divisor
//   funct3      RV32M funct3; [0]=unsigned, [1]=remainder ([2] ignored)
//   flush       pipeline squash; abandons any operation in progress
//   resp_valid  registered result available (DONE)
//   resp_ready  consumer takes the result
//   result      quotient or remainder, sign-corrected, registered
//   busy        high in CALC or DONE; execute-stage stall
//
// Build option:
//   DIV_SEQUENCER_EARLY_OUT_EN - when defined, an operation whose dividend
//   magnitude is below the divisor magnitude completes on the accept edge
//   (quotient 0, remainder = dividend) rather than iterating.
// -----------------------------------------------------------------------------
module div_sequencer #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned CNT_W = 5
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [XLEN-1:0] opa,
  input  logic [XLEN-1:0] opb,
  input  logic [2:0]      funct3,
  input  logic            flush,
  output logic            resp_valid,
  input  logic            resp_ready,
  output logic [XLEN-1:0] result,
  output logic            busy
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CALC = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [1:0]       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [XLEN-1:0]  r_rem;      // partial remainder accumulator
  logic [XLEN-1:0]  r_quo;      // dividend shifts out, quotient bits shift in
  logic [XLEN-1:0]  r_dvsr;     // divisor magnitude
  logic             r_neg_q;
  logic             r_neg_r;
  logic             r_sel_rem;  // funct3[1] of the accepted operation
  logic [XLEN-1:0]  r_result;
  logic             r_resp_valid;

  // funct3[2] is always 1 for M-extension divides and carries no information.
  logic w_unused;
  assign w_unused = funct3[2];

  // ---------------------------------------------------------------------------
  // Request decode (only meaningful in IDLE)
  // ---------------------------------------------------------------------------
  logic            w_signed;
  logic            w_neg_a;
  logic            w_neg_b;
  logic [XLEN-1:0] w_abs_a;
  logic [XLEN-1:0] w_abs_b;
  logic            w_div_zero;
  logic            w_overflow;
  logic            w_early;
  logic            w_short;     // operation completes on the accept edge
  logic [XLEN-1:0] w_short_res;

  assign w_signed   = ~funct3[0];
  assign w_neg_a    = w_signed & opa[XLEN-1];
  assign w_neg_b    = w_signed & opb[XLEN-1];
  assign w_abs_a    = w_neg_a ? (~opa + 1'b1) : opa;
  assign w_abs_b    = w_neg_b ? (~opb + 1'b1) : opb;
  assign w_div_zero = (opb == '0);
  assign w_overflow = w_signed & (opa == INT_MIN) & (opb == '1);

`ifdef DIV_SEQUENCER_EARLY_OUT_EN
  assign w_early = (w_abs_a < w_abs_b);
`else
  assign w_early = 1'b0;
`endif

  assign w_short = w_div_zero | w_overflow | w_early;

  // Results of the operations that bypass CALC. Divide-by-zero and the early
  // case both leave the original dividend as remainder, so no sign fix-up is
  // needed; overflow yields INT_MIN with zero remainder.
  always_comb begin
    w_short_res = '0;
    if (w_div_zero) begin
      w_short_res = funct3[1] ? opa : '1;
    end else if (w_overflow) begin
      w_short_res = funct3[1] ? '0 : INT_MIN;
    end else begin
      w_short_res = funct3[1] ? opa : '0;
    end
  end

  // ---------------------------------------------------------------------------
  // One restoring step
  // ---------------------------------------------------------------------------
  logic [XLEN:0]   w_shift;     // {rem, quo} shifted left, upper XLEN+1 bits
  logic [XLEN:0]   w_trial;
  logic            w_ge;
  logic [XLEN-1:0] w_rem_nxt;
  logic [XLEN-1:0] w_quo_nxt;
  logic [XLEN-1:0] w_q_fix;
  logic [XLEN-1:0] w_r_fix;
  logic [XLEN-1:0] w_calc_res;

  assign w_shift   = {r_rem, r_quo[XLEN-1]};
  assign w_trial   = w_shift - {1'b0, r_dvsr};
  assign w_ge      = ~w_trial[XLEN];
  assign w_rem_nxt = w_ge ? w_trial[XLEN-1:0] : w_shift[XLEN-1:0];
  assign w_quo_nxt = {r_quo[XLEN-2:0], w_ge};

  // Sign correction is applied to the final step's values so the result
  // register is loaded on the same edge that enters DONE.
  assign w_q_fix    = r_neg_q ? (~w_quo_nxt + 1'b1) : w_quo_nxt;
  assign w_r_fix    = r_neg_r ? (~w_rem_nxt + 1'b1) : w_rem_nxt;
  assign w_calc_res = r_sel_rem ? w_r_fix : w_q_fix;

  // ---------------------------------------------------------------------------
  // Sequencer
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_cnt        <= '0;
      r_rem        <= '0;
      r_quo        <= '0;
      r_dvsr       <= '0;
      r_neg_q      <= 1'b0;
      r_neg_r      <= 1'b0;
      r_sel_rem    <= 1'b0;
      r_result     <= '0;
      r_resp_valid <= 1'b0;
    end else if (flush) begin
      r_state      <= ST_IDLE;
      r_resp_valid <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (req_valid) begin
            r_sel_rem <= funct3[1];
            r_neg_q   <= w_neg_a ^ w_neg_b;
            r_neg_r   <= w_neg_a;
            r_dvsr    <= w_abs_b;
            r_quo     <= w_abs_a;
            r_rem     <= '0;
            r_cnt     <= '1;
            if (w_short) begin
              r_state      <= ST_DONE;
              r_result     <= w_short_res;
              r_resp_valid <= 1'b1;
            end else begin
              r_state <= ST_CALC;
            end
          end
        end
        ST_CALC: begin
          r_rem <= w_rem_nxt;
          r_quo <= w_quo_nxt;
          if (r_cnt == '0) begin
            r_state      <= ST_DONE;
            r_result     <= w_calc_res;
            r_resp_valid <= 1'b1;
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        ST_DONE: begin
          if (resp_ready) begin
            r_state      <= ST_IDLE;
            r_resp_valid <= 1'b0;
          end
        end
        default: begin
          r_state      <= ST_IDLE;
          r_resp_valid <= 1'b0;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign req_ready  = (r_state == ST_IDLE);
  assign busy       = (r_state == ST_CALC) | (r_state == ST_DONE);
  assign resp_valid = r_resp_valid;
  assign result     = r_result;

`ifndef SYNTHESIS
  a_valid_in_done : assert property (@(posedge clk) disable iff (!rst_n)
    r_resp_valid == (r_state == ST_DONE));
  a_legal_state : assert property (@(posedge clk) disable iff (!rst_n)
    r_state != 2'd3);
`endif

endmodule
